serial_rx_decoder: RTL and testbench
====================================

// Module: serial_rx_decoder
// PURPOSE
//   UART 8N1 receiver and ASCII digit decoder: the receive end of the serial link that the switch keypad transmits on.
//   Oversamples the rx line, recovers bytes, and maps the keypad's ASCII codes back to a 4-bit key value.
//   Feeds the display/readback logic on the far board. All logic is on one clock.
// PARAMETERS
//   CLKS_PER_BIT  10417  sysclk cycles per bit (100 MHz / 9600 baud); must be >= 4
//   SYNC_STAGES   2      rx synchroniser depth (2 or 3)
// PORTS
//   sysclk       in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   rx           in   1  serial line, idle high, LSB first
//   data         out  8  last correctly framed byte
//   data_valid   out  1  one-cycle pulse: data updated
//   digit        out  4  decoded key value of last valid byte
//   digit_valid  out  1  one-cycle pulse with data_valid when byte is a recognised code
//   frame_err    out  1  one-cycle pulse: stop bit sampled low
//   busy         out  1  high while state != IDLE
// BEHAVIOUR
//   Reset (async assert, sync release): data=8'h00, digit=4'h0, all pulses=0, busy=0, state=IDLE, counters=0, sync chain=1s.
//   rx passes SYNC_STAGES flops (reset to 1) before use; rx_s = synchronised rx. All timing is relative to rx_s.
//   States: IDLE, START, DATA, STOP, BREAK.
//   IDLE: on rx_s==0, go to START and clear the bit counter. The cycle counter counts to (CLKS_PER_BIT/2)-1.
//   START: at mid-bit, if rx_s==1, treat as a glitch and return to IDLE with no output.
//     If rx_s==0, go to DATA. The cycle counter reloads for a full CLKS_PER_BIT.
//   DATA: sample rx_s every CLKS_PER_BIT into a shift register, LSB first. After the 8th sample, go to STOP.
//   STOP: sample rx_s at mid-stop-bit.
//     If 1: on the next edge, data<=shift reg and data_valid=1 (plus digit/digit_valid if decoded); go to IDLE.
//     If 0: frame_err=1 for one cycle, data/digit unchanged; go to BREAK.
//   BREAK: hold until rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
//   Latency: data_valid rises 1 cycle after the stop-bit sample, i.e. 9.5*CLKS_PER_BIT+1 cycles after the start-bit edge on rx_s.
//   Re-arm: IDLE is re-entered at mid-stop-bit, so a start bit following immediately after the stop bit is not missed.
//   Decode (registered; updates only on a valid frame):
//     8'h30..8'h39 -> digit=0..9, digit_valid=1
//     8'h75 ('u')  -> digit=4'hF, digit_valid=1
//     anything else -> digit unchanged, digit_valid=0, data_valid still 1
//   Pulses are exactly one cycle and never overlap: data_valid and frame_err are mutually exclusive.
//   Counter width = $clog2(CLKS_PER_BIT); the counter never wraps inside a bit.
//   Reset mid-frame aborts the frame: no pulse is emitted, and the next falling edge after release starts a fresh frame.
// TESTING (bench uses CLKS_PER_BIT=16)
//   1. Send 8'h35 with a good stop bit -> data_valid once, data=8'h35, digit=4'h5, digit_valid=1, frame_err=0.
//   2. Send 8'h75 -> digit=4'hF, digit_valid=1. Then send 8'h41 -> data=8'h41, data_valid=1, digit_valid=0, digit stays 4'hF.
//   3. Send 8'h32 with the stop bit low -> frame_err one cycle, no data_valid, data unchanged.
//      Hold rx low 40 cycles, then release -> no further pulses.
//   4. Drive a 5-cycle low glitch on idle rx -> returns to IDLE, busy drops, no pulses.
//   5. Send 8'h30 and 8'h39 back-to-back with no idle gap -> two data_valid pulses.
//      Digits 0 then 9. Pulse spacing is 10*16 cycles.
//   6. Assert rst_n low during bit 4 of 8'h37 -> all outputs 0 asynchronously.
//      After release, send 8'h31 -> digit=4'h1 with exactly one data_valid.

Source files
------------

// File: rtl/serial_rx_decoder.sv
// UART 8N1 receiver with ASCII keypad-code decoder.
// Oversamples a synchronised rx line, frames bytes LSB first, and maps
// '0'..'9' to 0..9 and 'u' to 4'hF on the digit output.
module serial_rx_decoder #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       data_next;
  logic [3:0]       digit_next;
  logic             data_valid_next;
  logic             digit_valid_next;
  logic             frame_err_next;
  logic             busy_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser for the asynchronous rx line (idles high).
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data        <= '0;
      digit       <= '0;
      data_valid  <= 1'b0;
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_cnt     <= bit_next;
      shift       <= shift_next;
      data        <= data_next;
      digit       <= digit_next;
      data_valid  <= data_valid_next;
      digit_valid <= digit_valid_next;
      frame_err   <= frame_err_next;
      busy        <= busy_next;
    end
  end

  // Next-state, bit timing, shifting and decode.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    bit_next         = bit_cnt;
    shift_next       = shift;
    data_next        = data;
    digit_next       = digit;
    data_valid_next  = 1'b0;
    digit_valid_next = 1'b0;
    frame_err_next   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = START;
          bit_next   = '0;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            // Good frame: re-arm at mid-stop-bit so a back-to-back start is caught.
            state_next      = IDLE;
            data_next       = shift;
            data_valid_next = 1'b1;
            if (shift >= 8'h30 && shift <= 8'h39) begin
              digit_next       = shift[3:0];
              digit_valid_next = 1'b1;
            end else if (shift == 8'h75) begin
              digit_next       = 4'hF;
              digit_valid_next = 1'b1;
            end
          end else begin
            state_next     = BREAK;
            frame_err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_serial_rx_decoder.sv
// Scoreboard bench for serial_rx_decoder: stimulus pushes expected frame
// outcomes, a negedge monitor pops and compares on every output pulse.
module tb_serial_rx_decoder;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;
  // Start-bit drive to data_valid: 9.5 bits + 1 register + synchroniser depth.
  localparam int LAT = (19 * CPB) / 2 + 1 + SYNC;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic [3:0] digit;
  logic       digit_valid;
  logic       frame_err;
  logic       busy;

  serial_rx_decoder #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .digit       (digit),
    .digit_valid (digit_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [3:0] digit;
    bit         dig_v;
    int         start;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         last_dv = -1;
  int         prev_dv = -1;
  logic [7:0] m_data = 8'h00;
  logic [3:0] m_digit = 4'h0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected outcome of one frame from the receiver's rules.
  task automatic push_expect(input logic [7:0] b, input bit stop_ok, input int t0);
    exp_t e;
    e.is_err = !stop_ok;
    e.start  = t0;
    e.dig_v  = 1'b0;
    if (stop_ok) begin
      m_data = b;
      if (b >= 8'h30 && b <= 8'h39) begin
        m_digit = 4'(b - 8'h30);
        e.dig_v = 1'b1;
      end else if (b == 8'h75) begin
        m_digit = 4'hF;
        e.dig_v = 1'b1;
      end
    end
    e.data  = m_data;
    e.digit = m_digit;
    sb_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge sysclk);
    #1;
  endtask

  // Sends one 8N1 frame; called at posedge+1, returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    push_expect(b, stop_ok, cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge sysclk) begin
    if (rst_n && (data_valid || frame_err)) begin
      if (data_valid && frame_err) check("pulse_overlap", 32'(1), 32'(0));
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'({data_valid, frame_err}), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("frame_err", 32'(frame_err), 32'(e.is_err));
        check("data_valid", 32'(data_valid), 32'(!e.is_err));
        check("data", 32'(data), 32'(e.data));
        check("digit", 32'(digit), 32'(e.digit));
        check("digit_valid", 32'(digit_valid), 32'(e.dig_v));
        check("latency", 32'(cyc - e.start), 32'(LAT));
        if (data_valid) begin
          prev_dv = last_dv;
          last_dv = cyc;
        end
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    repeat (60000) @(posedge sysclk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] b37;
    bit         ok;

    // Reset state.
    repeat (4) @(posedge sysclk);
    #1;
    check("rst_data", 32'(data), 32'(0));
    check("rst_digit", 32'(digit), 32'(0));
    check("rst_pulses", 32'({data_valid, digit_valid, frame_err}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    idle_cycles(8);

    // 1: digit '5'.
    send_byte(8'h35, 1'b1);
    idle_cycles(20);

    // 2: 'u' then a non-digit keeps digit at F.
    send_byte(8'h75, 1'b1);
    idle_cycles(5);
    send_byte(8'h41, 1'b1);
    idle_cycles(20);

    // 3: bad stop bit, then a long-held low line yields a single frame_err.
    send_byte(8'h32, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge sysclk);
    #1;
    idle_cycles(10);
    check("break_busy", 32'(busy), 32'(0));
    idle_cycles(10);

    // 4: short low glitch is rejected.
    rx = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    check("glitch_busy_hi", 32'(busy), 32'(1));
    idle_cycles(30);
    check("glitch_busy_lo", 32'(busy), 32'(0));

    // 5: back-to-back frames.
    send_byte(8'h30, 1'b1);
    send_byte(8'h39, 1'b1);
    idle_cycles(20);
    check("b2b_spacing", 32'(last_dv - prev_dv), 32'(10 * CPB));

    // 6: reset during bit 4 of 8'h37 aborts the frame.
    b37 = 8'h37;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b37[i]);
    rx = b37[4];
    repeat (8) @(posedge sysclk);
    #3;
    rst_n = 1'b0;
    #1;
    m_data  = 8'h00;
    m_digit = 4'h0;
    check("arst_data", 32'(data), 32'(0));
    check("arst_digit", 32'(digit), 32'(0));
    check("arst_pulses", 32'({data_valid, digit_valid, frame_err}), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    rx = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    idle_cycles(6);
    send_byte(8'h31, 1'b1);
    idle_cycles(20);

    // Randomised frames: digits, 'u', arbitrary bytes, occasional bad stop bit.
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 2))
        0:       b = 8'h30 + 8'($urandom_range(0, 9));
        1:       b = 8'h75;
        default: b = 8'($urandom);
      endcase
      ok = ($urandom_range(0, 4) != 0);
      send_byte(b, ok);
      if (!ok) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 20)) @(posedge sysclk);
        #1;
        idle_cycles(CPB);
      end else begin
        idle_cycles($urandom_range(0, 20));
      end
    end

    idle_cycles(4 * CPB);
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    check("end_busy", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
